// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcode constants, immediate-width select and
// instruction field positions.
package cpu_pkg;

  localparam logic [4:0] OP_LOAD = 5'b10000;

  typedef enum logic [1:0] {
    IMM15 = 2'b00,
    IMM19 = 2'b01,
    IMM23 = 2'b10,
    IMM28 = 2'b11
  } imm_sel_t;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 19;
  localparam int RS2_HI = 18;
  localparam int RS2_LO = 15;
  localparam int IMM_HI = 27;
  localparam int IMM_LO = 0;

  function automatic imm_sel_t imm_sel_decode(input logic [4:0] opc);
    imm_sel_t sel;
    case (opc[4:3])
      2'b00, 2'b01: sel = IMM15;
      2'b10:        sel = IMM19;
      default:      sel = opc[2] ? IMM28 : IMM23;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the instruction in decode and the one
// being fetched. r0 is hardwired zero, so it never creates a dependency.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic [3:0] id_rd,
  input  logic       if_valid,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  output logic       haz
);

  // Source fields are compared whatever the incoming opcode is; a false
  // positive only costs one bubble.
  assign haz = id_valid && (id_opcode == OP_LOAD) && (id_rd != 4'd0) &&
               if_valid && ((rs1 == id_rd) || (rs2 == id_rd));

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline register: splits the fetched word into fields, selects the
// immediate width and inserts a bubble on load-use hazards.
module decode_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  id_opcode,
  output logic [3:0]  id_rd,
  output logic [3:0]  id_rs1,
  output logic [3:0]  id_rs2,
  output logic [27:0] id_imm_raw,
  output logic [1:0]  id_imm_sel,
  output logic [15:0] stall_cnt
);

  // Handshake: an instruction transfers on a rising edge where if_valid and
  // if_ready are both high; while if_valid=1 and if_ready=0 fetch holds
  // if_instr/if_pc. Under flush if_ready is high but the word is dropped.

  logic        id_valid_q,   id_valid_d;
  logic [31:0] id_pc_q,      id_pc_d;
  logic [31:0] id_instr_q,   id_instr_d;
  imm_sel_t    id_imm_sel_q, id_imm_sel_d;
  logic [15:0] stall_cnt_q,  stall_cnt_d;
  logic        haz;

  hazard_detect u_hazard_detect (
    .id_valid  (id_valid_q),
    .id_opcode (id_instr_q[OPC_HI:OPC_LO]),
    .id_rd     (id_instr_q[RD_HI:RD_LO]),
    .if_valid  (if_valid),
    .rs1       (if_instr[RS1_HI:RS1_LO]),
    .rs2       (if_instr[RS2_HI:RS2_LO]),
    .haz       (haz)
  );

  always_comb begin
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_imm_sel_d = id_imm_sel_q;
    stall_cnt_d  = stall_cnt_q;
    if_ready     = 1'b0;
    if (rst) begin
      if_ready = 1'b0;
    end else if (flush) begin
      if_ready     = 1'b1;
      id_valid_d   = 1'b0;
      id_imm_sel_d = IMM15;
    end else if (ex_stall) begin
      if_ready = 1'b0;
    end else if (haz) begin
      // The bubble itself clears haz, so the same word is taken next cycle.
      if_ready     = 1'b0;
      id_valid_d   = 1'b0;
      id_imm_sel_d = IMM15;
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      if_ready     = 1'b1;
      id_valid_d   = if_valid;
      id_pc_d      = if_pc;
      id_instr_d   = if_instr;
      id_imm_sel_d = if_valid ? imm_sel_decode(if_instr[OPC_HI:OPC_LO]) : IMM15;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'd0;
      id_instr_q   <= 32'd0;
      id_imm_sel_q <= IMM15;
      stall_cnt_q  <= 16'd0;
    end else begin
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      id_imm_sel_q <= id_imm_sel_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_opcode  = id_instr_q[OPC_HI:OPC_LO];
  assign id_rd      = id_instr_q[RD_HI:RD_LO];
  assign id_rs1     = id_instr_q[RS1_HI:RS1_LO];
  assign id_rs2     = id_instr_q[RS2_HI:RS2_LO];
  assign id_imm_raw = id_instr_q[IMM_HI:IMM_LO];
  assign id_imm_sel = id_imm_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written reset and
// saturation sequences, then random traffic against a pipeline model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_opcode;
  logic [3:0]  id_rd;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic [27:0] id_imm_raw;
  logic [1:0]  id_imm_sel;
  logic [15:0] stall_cnt;

  int tests  = 0;
  int errors = 0;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .ex_stall   (ex_stall),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_opcode  (id_opcode),
    .id_rd      (id_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_imm_raw (id_imm_raw),
    .id_imm_sel (id_imm_sel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs away from the active edge.
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic st, input logic fl, input logic r);
    @(negedge clk);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
    ex_stall = st;
    flush    = fl;
    rst      = r;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_opcode"}, 32'(id_opcode), 32'd0);
    check({tag, "_rd"}, 32'(id_rd), 32'd0);
    check({tag, "_rs1"}, 32'(id_rs1), 32'd0);
    check({tag, "_rs2"}, 32'(id_rs2), 32'd0);
    check({tag, "_imm_raw"}, 32'(id_imm_raw), 32'd0);
    check({tag, "_imm_sel"}, 32'(id_imm_sel), 32'd0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic [14:0] low);
    return {opc, rd, rs1, rs2, low};
  endfunction

  // Immediate width from the opcode's numeric range.
  function automatic logic [1:0] ref_imm_sel(input logic [4:0] opc);
    if (opc < 5'd16)      return 2'd0;
    else if (opc < 5'd24) return 2'd1;
    else if (opc < 5'd28) return 2'd2;
    else                  return 2'd3;
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [4:0]  exp_opc;
    logic [1:0]  exp_sel;
    logic [27:0] exp_imm;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  // Reference model state: what the decode register should hold.
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_stall = 1'b0; flush = 1'b0;

    vecs[0]  = '{1'b1, 32'h4000_0123, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 5'h08, 2'd0, 28'h000_0123, 16'd0};
    vecs[1]  = '{1'b1, 32'hE000_0000, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 5'h1C, 2'd3, 28'h000_0000, 16'd0};
    vecs[2]  = '{1'b1, 32'hC000_0000, 32'h108, 1'b0, 1'b0, 1'b1, 1'b1, 32'h108, 5'h18, 2'd2, 28'h000_0000, 16'd0};
    vecs[3]  = '{1'b1, 32'h8180_0000, 32'h10C, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10C, 5'h10, 2'd1, 28'h180_0000, 16'd0};
    vecs[4]  = '{1'b1, 32'h0801_8000, 32'h110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   5'h00, 2'd0, 28'h000_0000, 16'd1};
    vecs[5]  = '{1'b1, 32'h0801_8000, 32'h110, 1'b0, 1'b0, 1'b1, 1'b1, 32'h110, 5'h01, 2'd0, 28'h801_8000, 16'd1};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h114, 1'b0, 1'b0, 1'b1, 1'b1, 32'h114, 5'h10, 2'd1, 28'h000_0000, 16'd1};
    vecs[7]  = '{1'b1, 32'h0800_0000, 32'h118, 1'b0, 1'b0, 1'b1, 1'b1, 32'h118, 5'h01, 2'd0, 28'h800_0000, 16'd1};
    vecs[8]  = '{1'b1, 32'hE000_0000, 32'h11C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h118, 5'h01, 2'd0, 28'h800_0000, 16'd1};
    vecs[9]  = '{1'b1, 32'hE000_0000, 32'h11C, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   5'h00, 2'd0, 28'h000_0000, 16'd1};
    vecs[10] = '{1'b1, 32'hE000_0000, 32'h11C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   5'h00, 2'd0, 28'h000_0000, 16'd1};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   5'h00, 2'd0, 28'h000_0000, 16'd1};

    // Reset state and if_ready held low during reset.
    drive(1'b1, 32'h4000_0123, 32'h100, 1'b0, 1'b0, 1'b1);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    edge_sample();
    check_reset_outputs("rst");

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].instr, vecs[i].pc, vecs[i].st, vecs[i].fl, 1'b0);
      check($sformatf("vec%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].exp_ready));
      edge_sample();
      check($sformatf("vec%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_id_opcode", i), 32'(id_opcode), 32'(vecs[i].exp_opc));
        check($sformatf("vec%0d_id_imm_raw", i), 32'(id_imm_raw), 32'(vecs[i].exp_imm));
      end
      check($sformatf("vec%0d_id_imm_sel", i), 32'(id_imm_sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_cnt));
    end

    // Saturation: preload the counter, then provoke a hazard.
    @(negedge clk);
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    check("sat_preload", 32'(stall_cnt), 32'hFFFF);
    drive(1'b1, mk(5'h10, 4'd5, 4'd0, 4'd0, 15'h0), 32'h200, 1'b0, 1'b0, 1'b0);
    edge_sample();
    drive(1'b1, mk(5'h02, 4'd1, 4'd5, 4'd0, 15'h7), 32'h204, 1'b0, 1'b0, 1'b0);
    check("sat_haz_if_ready", 32'(if_ready), 32'd0);
    edge_sample();
    check("sat_bubble", 32'(id_valid), 32'd0);
    check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);

    // Reset arriving in a hazard cycle: no residual bubble after release.
    drive(1'b1, mk(5'h10, 4'd5, 4'd0, 4'd0, 15'h0), 32'h300, 1'b0, 1'b0, 1'b0);
    edge_sample();
    drive(1'b1, mk(5'h02, 4'd1, 4'd5, 4'd0, 15'h7), 32'h304, 1'b0, 1'b0, 1'b1);
    check("rsthaz_if_ready", 32'(if_ready), 32'd0);
    edge_sample();
    check_reset_outputs("rsthaz");
    drive(1'b1, mk(5'h02, 4'd1, 4'd5, 4'd0, 15'h7), 32'h304, 1'b0, 1'b0, 1'b0);
    check("rsthaz_release_ready", 32'(if_ready), 32'd1);
    edge_sample();
    check("rsthaz_release_valid", 32'(id_valid), 32'd1);
    check("rsthaz_release_pc", id_pc, 32'h304);

    // Reset arriving while stalled discards the held instruction.
    drive(1'b1, mk(5'h03, 4'd2, 4'd0, 4'd0, 15'h0), 32'h308, 1'b1, 1'b0, 1'b1);
    check("rststall_if_ready", 32'(if_ready), 32'd0);
    edge_sample();
    check("rststall_valid", 32'(id_valid), 32'd0);

    // Random traffic against the model.
    m_valid = 1'b0; m_instr = '0; m_pc = '0; m_cnt = '0;
    for (int n = 0; n < 3000; n++) begin
      logic        v, st, fl, r, haz, exp_ready;
      logic [4:0]  opc;
      logic [31:0] instr, pc;
      v   = ($urandom_range(0, 3) != 0);
      opc = ($urandom_range(0, 2) == 0) ? 5'h10 : 5'($urandom_range(0, 31));
      instr = mk(opc, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 15'($urandom));
      pc  = $urandom;
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 99) == 0);
      drive(v, instr, pc, st, fl, r);

      haz = m_valid && (m_instr[31:27] == 5'h10) && (m_instr[26:23] != 4'd0) && v &&
            ((instr[22:19] == m_instr[26:23]) || (instr[18:15] == m_instr[26:23]));
      if (r) begin
        exp_ready = 1'b0;
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_cnt = '0;
      end else if (fl) begin
        exp_ready = 1'b1;
        m_valid = 1'b0;
      end else if (st) begin
        exp_ready = 1'b0;
      end else if (haz) begin
        exp_ready = 1'b0;
        m_valid = 1'b0;
        if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        exp_ready = 1'b1;
        m_valid = v;
        m_instr = instr;
        m_pc    = pc;
      end
      check("rnd_if_ready", 32'(if_ready), 32'(exp_ready));
      edge_sample();
      check("rnd_id_valid", 32'(id_valid), 32'(m_valid));
      check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      check("rnd_id_imm_sel", 32'(id_imm_sel), m_valid ? 32'(ref_imm_sel(m_instr[31:27])) : 32'd0);
      if (m_valid) begin
        check("rnd_id_pc", id_pc, m_pc);
        check("rnd_id_opcode", 32'(id_opcode), 32'(m_instr[31:27]));
        check("rnd_id_rd", 32'(id_rd), 32'(m_instr[26:23]));
        check("rnd_id_rs1", 32'(id_rs1), 32'(m_instr[22:19]));
        check("rnd_id_rs2", 32'(id_rs2), 32'(m_instr[18:15]));
        check("rnd_id_imm_raw", 32'(id_imm_raw), 32'(m_instr[27:0]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have a single clock and a reset, where the reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 if_valid  input  1  fetch presents an instruction.
REQ-005 if_instr  input  32  fetched instruction word.
REQ-006 if_pc  input  32  PC of if_instr.
REQ-007 if_ready  output  1  the block accepts if_instr this cycle (combinational).
REQ-008 ex_stall  input  1  downstream cannot accept; hold the decode register.
REQ-009 flush  input  1  branch taken; discard decode contents and the incoming instruction.
REQ-010 id_valid  output  1  decode register holds a real instruction (0 = bubble).
REQ-011 id_pc  output  32  registered PC.
REQ-012 id_opcode  output  5  registered instr[31:27].
REQ-013 id_rd, id_rs1, id_rs2  output  4 each  registered instr[26:23], [22:19], [18:15].
REQ-014 id_imm_raw  output  28  registered instr[27:0]; drives the immediate extender input.
REQ-015 id_imm_sel  output  2  registered immediate-width select: 00=15b, 01=19b, 10=23b, 11=28b.
REQ-016 stall_cnt  output  16  saturating count of load-use bubbles since reset.

Function
REQ-017 imm_sel decode SHALL use opcode[4:3]: 00->00, 01->00, 10->01; for 11, opcode[2]=1->11, else 10.
REQ-018 Load-use hazard (haz) SHALL be asserted when id_valid=1, id_opcode=OP_LOAD, id_rd!=0, if_valid=1, and (if_instr[22:19]==id_rd or if_instr[18:15]==id_rd); the compare SHALL run regardless of the incoming opcode.
REQ-019 Per-edge priority SHALL be rst > flush > ex_stall > haz > normal.
REQ-020 flush: the next id_valid SHALL be 0, if_ready SHALL be 1, and the incoming instruction SHALL be dropped.
REQ-021 ex_stall (no flush): all id_* registers SHALL hold, and if_ready SHALL be 0.
REQ-022 haz (no flush/ex_stall): the next id_valid SHALL be 0 (bubble), if_ready SHALL be 0, stall_cnt SHALL increment unless it is 0xFFFF, and the same instruction SHALL be accepted the following cycle because the bubble clears haz.
REQ-023 Normal: if_ready SHALL be 1; on the next edge id_valid SHALL take the value of if_valid, and all fields SHALL load from if_instr/if_pc.
REQ-024 Latency SHALL be one cycle from acceptance to id_* outputs.
REQ-025 When id_valid=0, payload fields SHALL be don't-care except id_imm_sel, which SHALL be 00.
REQ-026 Register 0 SHALL never cause a hazard.
REQ-027 stall_cnt SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-028 On rst: id_valid=0, id_pc=0, id_opcode=0, id_rd/rs1/rs2=0, id_imm_raw=0, id_imm_sel=00, and stall_cnt=0.
REQ-029 During rst, if_ready SHALL be 0.
REQ-030 A reset asserted mid-stall or mid-hazard SHALL discard the held instruction, with no residual bubble after release.

Structure
REQ-031 Package cpu_pkg SHALL hold OP_LOAD (5'b10000), the imm_sel_t enum (IMM15, IMM19, IMM23, IMM28), and the field bit-position constants.
REQ-032 The combinational hazard compare SHALL be the sub-module hazard_detect (inputs id_valid, id_opcode, id_rd, if_valid, rs1, rs2; output haz).

Verification
REQ-033 Reset, then if_valid=1, if_instr=0x40000123, pc=0x100 -> next cycle id_valid=1, id_opcode=0x08, id_imm_sel=00, id_imm_raw=0x0000123.
REQ-034 Opcode 0x1C (11100) then 0x18 (11000) back-to-back -> id_imm_sel 11 then 10, with both accepted on consecutive cycles.
REQ-035 Load with rd=3 followed by an instruction with rs2=3 -> if_ready=0 for one cycle, one bubble (id_valid=0), stall_cnt=1, and the dependent instruction appears in ID on the following cycle.
REQ-036 Load with rd=0 followed by a reader of r0 -> no bubble and stall_cnt unchanged.
REQ-037 ex_stall=1 for 3 cycles with flush=1 in cycle 2 -> ID holds in cycle 1, then id_valid=0 after the cycle-2 edge, and if_ready=1 in cycle 2.
REQ-038 Force stall_cnt to 0xFFFF, then trigger a hazard -> stall_cnt stays at 0xFFFF; assert rst during a hazard cycle -> all outputs at reset values on the next edge.
